// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Holds the MEM-wait FSM encoding, the stage-control bundle and the x0 register constant.
package hazard_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_WAIT = 2'd1,
      M_ERR  = 2'd2
   } mem_state_e;

   // Load enables and bubble-insert controls for the PC and the four stage registers
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } pipe_ctrl_t;

   // True when a source operand that is actually read matches the producing rd
   function automatic logic src_hits(
      input logic                  uses,
      input logic [REG_ADDR_W-1:0] src,
      input logic [REG_ADDR_W-1:0] rd
   );
      return uses && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing control: load-use, redirect and data-memory wait handling.
// Enables/flushes are combinational; the MEM-wait FSM, watchdog and counters are registered.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
   input  logic                  i_id_uses_rs1,
   input  logic                  i_id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
   input  logic                  i_ex_mem_read,
   input  logic                  i_ex_redirect,
   input  logic                  i_dmem_req,
   input  logic                  i_dmem_ready,
   output logic                  o_pc_en,
   output logic                  o_if_id_en,
   output logic                  o_id_ex_en,
   output logic                  o_ex_mem_en,
   output logic                  o_mem_wb_en,
   output logic                  o_if_id_flush,
   output logic                  o_id_ex_flush,
   output logic                  o_ex_mem_flush,
   output logic                  o_mem_wb_flush,
   output logic                  o_mem_stall,
   output logic                  o_dmem_timeout,
   output logic [CNT_W-1:0]      o_stall_cycles,
   output logic [CNT_W-1:0]      o_redirect_count
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   mem_state_e        r_state;
   mem_state_e        w_state_nxt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_cnt_nxt;
   logic              r_timeout;
   logic              w_timeout_nxt;

   logic              w_load_use;
   logic              w_mem_stall;
   logic              w_stall_inc;
   logic              w_redirect_inc;
   pipe_ctrl_t        w_ctrl;

   // A load targeting x0 never produces a value, so it can never create a hazard
   assign w_load_use = i_ex_mem_read
                    && (i_ex_rd_addr != REG_X0)
                    && (src_hits(i_id_uses_rs1, i_id_rs1_addr, i_ex_rd_addr)
                     || src_hits(i_id_uses_rs2, i_id_rs2_addr, i_ex_rd_addr));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= M_IDLE;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   // MEM-wait FSM with watchdog; M_ERR is terminal until reset
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_timeout_nxt  = r_timeout;
      w_mem_stall    = 1'b0;
      unique case (r_state)
         M_IDLE: begin
            w_mem_stall = i_dmem_req && !i_dmem_ready;
            if (w_mem_stall) begin
               w_state_nxt    = M_WAIT;
               w_wait_cnt_nxt = WAIT_W'(1);
            end
         end
         M_WAIT: begin
            w_mem_stall = !i_dmem_ready;
            if (i_dmem_ready) begin
               w_state_nxt    = M_IDLE;
               w_wait_cnt_nxt = '0;
            end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
               w_state_nxt   = M_ERR;
               w_timeout_nxt = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         M_ERR: begin
            w_mem_stall   = 1'b1;
            w_timeout_nxt = 1'b1;
         end
         default: begin
            w_mem_stall   = 1'b1;
            w_state_nxt   = M_ERR;
            w_timeout_nxt = 1'b1;
         end
      endcase
   end

   // Stage control, highest priority first: mem wait, redirect, load-use
   always_comb begin
      w_ctrl = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                 mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
                 ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};
      if (!i_rst_n) begin
         w_ctrl.pc_en        = 1'b0;
         w_ctrl.if_id_flush  = 1'b1;
         w_ctrl.id_ex_flush  = 1'b1;
         w_ctrl.ex_mem_flush = 1'b1;
         w_ctrl.mem_wb_flush = 1'b1;
      end else if (w_mem_stall) begin
         // EX is frozen, so redirect/load-use get re-evaluated after release
         w_ctrl.pc_en        = 1'b0;
         w_ctrl.if_id_en     = 1'b0;
         w_ctrl.id_ex_en     = 1'b0;
         w_ctrl.ex_mem_en    = 1'b0;
         w_ctrl.mem_wb_flush = 1'b1;
      end else if (i_ex_redirect) begin
         w_ctrl.if_id_flush = 1'b1;
         w_ctrl.id_ex_flush = 1'b1;
      end else if (w_load_use) begin
         w_ctrl.pc_en       = 1'b0;
         w_ctrl.if_id_en    = 1'b0;
         w_ctrl.id_ex_flush = 1'b1;
      end
   end

   assign o_pc_en        = w_ctrl.pc_en;
   assign o_if_id_en     = w_ctrl.if_id_en;
   assign o_id_ex_en     = w_ctrl.id_ex_en;
   assign o_ex_mem_en    = w_ctrl.ex_mem_en;
   assign o_mem_wb_en    = w_ctrl.mem_wb_en;
   assign o_if_id_flush  = w_ctrl.if_id_flush;
   assign o_id_ex_flush  = w_ctrl.id_ex_flush;
   assign o_ex_mem_flush = w_ctrl.ex_mem_flush;
   assign o_mem_wb_flush = w_ctrl.mem_wb_flush;
   assign o_mem_stall    = i_rst_n && w_mem_stall;
   assign o_dmem_timeout = r_timeout;

   assign w_stall_inc    = w_mem_stall || (w_load_use && !i_ex_redirect);
   assign w_redirect_inc = i_ex_redirect && !w_mem_stall;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_stall_inc),
      .o_count (o_stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_redirect_inc),
      .o_count (o_redirect_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazards, redirects, MEM waits, watchdog and counter saturation.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_hazard_ctrl;

   localparam logic [9:0] C_RST = 10'b0_1111_1111_0;
   localparam logic [9:0] C_RUN = 10'b1_1111_0000_0;
   localparam logic [9:0] C_LU  = 10'b0_0111_0100_0;
   localparam logic [9:0] C_RDR = 10'b1_1111_1100_0;
   localparam logic [9:0] C_MEM = 10'b0_0001_0001_1;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
   logic       i_id_uses_rs1, i_id_uses_rs2, i_ex_mem_read, i_ex_redirect;
   logic       i_dmem_req, i_dmem_ready;

   logic        o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
   logic        o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush;
   logic        o_mem_stall, o_dmem_timeout;
   logic [15:0] o_stall_cycles, o_redirect_count;

   logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
   logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
   logic        s_mem_stall, s_dmem_timeout;
   logic [1:0]  s_stall_cycles, s_redirect_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
      .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
      .i_ex_rd_addr(i_ex_rd_addr), .i_ex_mem_read(i_ex_mem_read),
      .i_ex_redirect(i_ex_redirect), .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready),
      .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
      .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en),
      .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
      .o_ex_mem_flush(o_ex_mem_flush), .o_mem_wb_flush(o_mem_wb_flush),
      .o_mem_stall(o_mem_stall), .o_dmem_timeout(o_dmem_timeout),
      .o_stall_cycles(o_stall_cycles), .o_redirect_count(o_redirect_count)
   );

   hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(2)) u_dut_sat (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
      .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
      .i_ex_rd_addr(i_ex_rd_addr), .i_ex_mem_read(i_ex_mem_read),
      .i_ex_redirect(i_ex_redirect), .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready),
      .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en), .o_id_ex_en(s_id_ex_en),
      .o_ex_mem_en(s_ex_mem_en), .o_mem_wb_en(s_mem_wb_en),
      .o_if_id_flush(s_if_id_flush), .o_id_ex_flush(s_id_ex_flush),
      .o_ex_mem_flush(s_ex_mem_flush), .o_mem_wb_flush(s_mem_wb_flush),
      .o_mem_stall(s_mem_stall), .o_dmem_timeout(s_dmem_timeout),
      .o_stall_cycles(s_stall_cycles), .o_redirect_count(s_redirect_count)
   );

   function automatic logic [9:0] ctrl_vec();
      return {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
              o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush, o_mem_stall};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_id(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
      i_id_uses_rs1 = u1;
      i_id_rs1_addr = r1;
      i_id_uses_rs2 = u2;
      i_id_rs2_addr = r2;
   endtask

   task automatic set_ex(input logic rd_mem, input logic [4:0] rd);
      i_ex_mem_read = rd_mem;
      i_ex_rd_addr  = rd;
   endtask

   initial begin
      i_rst_n = 1'b0;
      set_id(1'b0, 5'd0, 1'b0, 5'd0);
      set_ex(1'b0, 5'd0);
      i_ex_redirect = 1'b0;
      i_dmem_req    = 1'b0;
      i_dmem_ready  = 1'b0;

      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         check("rst_ctrl", 32'(ctrl_vec()), 32'(C_RST));
         step();
      end
      check("rst_stall_cnt", 32'(o_stall_cycles), 32'd0);
      check("rst_redir_cnt", 32'(o_redirect_count), 32'd0);
      check("rst_timeout", 32'(o_dmem_timeout), 32'd0);

      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("idle_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
      step();

      // lw x5 in EX, ID reads x5 through rs2
      set_ex(1'b1, 5'd5);
      set_id(1'b1, 5'd3, 1'b1, 5'd5);
      @(negedge i_clk);
      check("lu_rs2_ctrl", 32'(ctrl_vec()), 32'(C_LU));
      step();
      set_ex(1'b0, 5'd0);
      @(negedge i_clk);
      check("lu_rs2_after", 32'(ctrl_vec()), 32'(C_RUN));
      check("lu_rs2_cnt", 32'(o_stall_cycles), 32'd1);
      check("lu_rs2_sat_cnt", 32'(s_stall_cycles), 32'd1);
      step();

      // lw x7, ID reads x7 through rs1
      set_ex(1'b1, 5'd7);
      set_id(1'b1, 5'd7, 1'b0, 5'd7);
      @(negedge i_clk);
      check("lu_rs1_ctrl", 32'(ctrl_vec()), 32'(C_LU));
      step();
      check("lu_rs1_cnt", 32'(o_stall_cycles), 32'd2);

      // rs1 address matches but is not read
      set_ex(1'b1, 5'd9);
      set_id(1'b0, 5'd9, 1'b1, 5'd4);
      @(negedge i_clk);
      check("nouse_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
      step();
      check("nouse_cnt", 32'(o_stall_cycles), 32'd2);

      // lw x0 never creates a hazard
      set_ex(1'b1, 5'd0);
      set_id(1'b1, 5'd0, 1'b1, 5'd0);
      @(negedge i_clk);
      check("x0_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
      step();
      check("x0_cnt", 32'(o_stall_cycles), 32'd2);

      // redirect wins over a coincident load-use
      set_ex(1'b1, 5'd5);
      set_id(1'b0, 5'd0, 1'b1, 5'd5);
      i_ex_redirect = 1'b1;
      @(negedge i_clk);
      check("rdr_lu_ctrl", 32'(ctrl_vec()), 32'(C_RDR));
      step();
      i_ex_redirect = 1'b0;
      set_ex(1'b0, 5'd0);
      check("rdr_lu_redir_cnt", 32'(o_redirect_count), 32'd1);
      check("rdr_lu_stall_cnt", 32'(o_stall_cycles), 32'd2);

      // three-cycle MEM wait with a redirect held throughout
      i_dmem_req    = 1'b1;
      i_dmem_ready  = 1'b0;
      i_ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         check("mem_wait_ctrl", 32'(ctrl_vec()), 32'(C_MEM));
         step();
      end
      i_dmem_ready = 1'b1;
      @(negedge i_clk);
      check("mem_release_ctrl", 32'(ctrl_vec()), 32'(C_RDR));
      step();
      i_dmem_req    = 1'b0;
      i_dmem_ready  = 1'b0;
      i_ex_redirect = 1'b0;
      check("mem_wait_stall_cnt", 32'(o_stall_cycles), 32'd5);
      check("mem_wait_redir_cnt", 32'(o_redirect_count), 32'd2);

      // request completing in the same cycle costs nothing
      i_dmem_req   = 1'b1;
      i_dmem_ready = 1'b1;
      @(negedge i_clk);
      check("mem_fast_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
      step();
      check("mem_fast_cnt", 32'(o_stall_cycles), 32'd5);

      // watchdog: ready never arrives
      i_dmem_req   = 1'b1;
      i_dmem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("to_wait_ctrl", 32'(ctrl_vec()), 32'(C_MEM));
         check("to_wait_flag", 32'(o_dmem_timeout), 32'd0);
         step();
      end
      check("to_flag", 32'(o_dmem_timeout), 32'd1);
      check("to_stall_cnt", 32'(o_stall_cycles), 32'd10);
      check("sat_stall_cnt", 32'(s_stall_cycles), 32'd3);
      check("sat_redir_cnt", 32'(s_redirect_count), 32'd2);

      // error state ignores a late ready
      i_dmem_ready = 1'b1;
      @(negedge i_clk);
      check("err_hold_ctrl", 32'(ctrl_vec()), 32'(C_MEM));
      step();
      check("err_hold_flag", 32'(o_dmem_timeout), 32'd1);

      // one-cycle reset clears the error
      i_rst_n      = 1'b0;
      i_dmem_req   = 1'b0;
      i_dmem_ready = 1'b0;
      @(negedge i_clk);
      check("err_rst_ctrl", 32'(ctrl_vec()), 32'(C_RST));
      step();
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("post_rst_ctrl", 32'(ctrl_vec()), 32'(C_RUN));
      check("post_rst_flag", 32'(o_dmem_timeout), 32'd0);
      check("post_rst_stall_cnt", 32'(o_stall_cycles), 32'd0);
      check("post_rst_redir_cnt", 32'(o_redirect_count), 32'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central sequencing/control block for the 5-stage pipeline.
- Generates the load-enable and flush (bubble-insert) controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, EX-stage redirects (taken branch/jump) and multi-cycle data-memory waits.
- Runs a data-memory wait FSM with a watchdog, plus saturating performance counters.

Parameters:
- TIMEOUT_CYCLES, 255: max consecutive MEM-wait cycles before fatal timeout.
- CNT_W, 16: width of the performance counters.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_id_rs1_addr  in  5  rs1 of instruction in ID.
- i_id_rs2_addr  in  5  rs2 of instruction in ID.
- i_id_uses_rs1  in  1  ID instruction reads rs1.
- i_id_uses_rs2  in  1  ID instruction reads rs2.
- i_ex_rd_addr  in  5  rd of instruction in EX.
- i_ex_mem_read  in  1  EX instruction is a load.
- i_ex_redirect  in  1  EX resolved taken branch/jump; PC redirect this cycle.
- i_dmem_req  in  1  MEM stage issuing load/store this cycle.
- i_dmem_ready  in  1  data memory completes the access this cycle.
- o_pc_en  out  1  PC register load enable.
- o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage-register load enables.
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush  out  1 each  when the matching enable is 1, load a bubble (all control bits 0) instead of data.
- o_mem_stall  out  1  MEM wait in progress (diagnostic).
- o_dmem_timeout  out  1  sticky fatal-timeout flag.
- o_stall_cycles  out  CNT_W  saturating count of stalled cycles.
- o_redirect_count  out  CNT_W  saturating count of redirects.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - FSM goes to M_IDLE; wait counter, o_dmem_timeout and both performance counters clear to 0.
  - While i_rst_n is low, all *_en=1 and all *_flush=1, so every stage register loads a bubble. o_pc_en=0 and o_mem_stall=0.
  - Reset mid-wait aborts the wait with no residual stall.
- Hazard signals (combinational):
  - load_use = i_ex_mem_read & (i_ex_rd_addr!=0) & ((i_id_uses_rs1 & rs1==rd) | (i_id_uses_rs2 & rs2==rd)).
  - A write to x0 never causes a hazard.
- FSM states:
  - M_IDLE: mem_stall = i_dmem_req & !i_dmem_ready.
    - If mem_stall, go to M_WAIT with wait counter = 1.
    - A req with ready in the same cycle gives zero stall.
  - M_WAIT: mem_stall = !i_dmem_ready.
    - If ready, go to M_IDLE; the pipeline advances in that same cycle.
    - Else wait counter increments. At counter==TIMEOUT_CYCLES with no ready, go to M_ERR.
  - M_ERR: mem_stall=1 permanently and o_dmem_timeout=1. Only reset exits.
  - o_mem_stall = mem_stall.
- Output priority, highest first:
  1. mem_stall: o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en = 0. o_mem_wb_en=1 with o_mem_wb_flush=1 (WB receives a bubble). i_ex_redirect and load_use are ignored; EX is frozen, so they are re-evaluated after release.
  2. i_ex_redirect: all enables 1; o_if_id_flush=1, o_id_ex_flush=1. A coincident load_use is discarded because the ID instruction is squashed.
  3. load_use: o_pc_en=0, o_if_id_en=0; o_id_ex_en=1 with o_id_ex_flush=1; EX/MEM and MEM/WB advance. Exactly one bubble per load-use.
  4. Otherwise: all enables 1, all flushes 0.
- Counters:
  - o_stall_cycles increments in each cycle where mem_stall | (load_use & !i_ex_redirect).
  - o_redirect_count increments when i_ex_redirect & !mem_stall.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Latency: all enable/flush outputs are combinational from the current inputs and state. FSM and counter updates take effect at the next edge.

Decomposition:
- Shared package: FSM state encoding (M_IDLE=2'd0, M_WAIT=2'd1, M_ERR=2'd2) and the REG_X0=5'd0 constant.
- One natural sub-module: sat_counter (parameterised width, inc, synchronous active-low clear). Instantiate it twice.

Test Plan:
- Reset hold for 3 cycles → all *_en=1, all *_flush=1, o_pc_en=0, counters 0, o_dmem_timeout=0.
- EX lw x5 with ID add using rs2=x5 → one cycle of o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; next cycle all flushes 0; o_stall_cycles=1.
- EX lw x0 with ID using x0 → no stall, o_stall_cycles unchanged.
- i_ex_redirect=1 coincident with load_use → o_if_id_flush=o_id_ex_flush=1, o_pc_en=1; o_redirect_count=1, o_stall_cycles unchanged.
- i_dmem_req=1 with ready after 3 cycles → o_mem_stall high for exactly 3 cycles, o_mem_wb_flush=1 during those cycles, o_stall_cycles=3; a redirect held during the wait takes effect only in the release cycle.
- TIMEOUT_CYCLES=4, ready never asserted → o_dmem_timeout=1 at the 5th cycle after req; then release i_rst_n low for one cycle → state M_IDLE, flag cleared.
